// File: rtl/xup_xor_descrambler_if.sv
// Valid/ready word bus between the link receiver, the descrambler and the consumer.
interface xup_xor_descrambler_if #(
  parameter int SIZE = 8
);
  logic            valid;
  logic            ready;
  logic [SIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/xup_xor_descrambler.sv
// Purpose: regenerates the transmit keystream (Galois LFSR) and XORs it onto framed scrambled words.
// Latency: 1 cycle from accept to m.valid; 1 word/clk while m.ready is held high.
// Backpressure: s.ready drops while the output register is full and not being taken.
module xup_xor_descrambler #(
  parameter int              SIZE      = 8,
  parameter logic [SIZE-1:0] POLY      = 8'hB8,
  parameter int              FRAME_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   seed_load,
  input  logic [SIZE-1:0]        seed,
  xup_xor_descrambler_if.slave   s,
  xup_xor_descrambler_if.master  m,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]      state;
  logic [SIZE-1:0] lfsr;
  logic [CW-1:0]   count;
  logic            m_valid_q;
  logic [SIZE-1:0] m_data_q;
  logic            accept;
  logic            take;
  logic            last_word;

  function automatic logic [SIZE-1:0] step(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ POLY;
    return r;
  endfunction

  assign s.ready   = (state == ST_RUN) && (!m_valid_q || m.ready);
  assign accept    = s.valid && s.ready;
  assign take      = m_valid_q && m.ready;
  assign last_word = (count == CW'(FRAME_LEN - 1));

  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lfsr       <= SIZE'(1);
      count      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Key only moves on accept so stalls never desynchronise it from the transmitter.
      if (accept) begin
        m_data_q  <= s.data ^ lfsr;
        m_valid_q <= 1'b1;
        lfsr      <= step(lfsr);
        count     <= count + CW'(1);
      end else if (take) begin
        m_valid_q <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (seed_load) begin
            lfsr  <= (seed == '0) ? SIZE'(1) : seed;
            count <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept && last_word) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (take) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xup_xor_descrambler.sv
// Directed bench for xup_xor_descrambler: a FRAME_LEN=4 instance for hand-computed vectors
// and a FRAME_LEN=16 instance for random handshake gaps against a keystream model.
module tb_xup_xor_descrambler;

  logic       clk;
  logic       reset;
  logic       seed_load;
  logic [7:0] seed;
  logic       fd4, busy4, fd16, busy16;

  int checks = 0;
  int errors = 0;

  xup_xor_descrambler_if #(.SIZE(8)) s4();
  xup_xor_descrambler_if #(.SIZE(8)) m4();
  xup_xor_descrambler_if #(.SIZE(8)) s16();
  xup_xor_descrambler_if #(.SIZE(8)) m16();

  xup_xor_descrambler #(.SIZE(8), .POLY(8'hB8), .FRAME_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed),
    .s(s4), .m(m4), .frame_done(fd4), .busy(busy4)
  );

  logic       seed_load16;
  logic [7:0] seed16;

  xup_xor_descrambler #(.SIZE(8), .POLY(8'hB8), .FRAME_LEN(16)) dut16 (
    .clk(clk), .reset(reset), .seed_load(seed_load16), .seed(seed16),
    .s(s16), .m(m16), .frame_done(fd16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full 4-word frame at full throughput; dexp holds word 0 in its low byte.
  task automatic run_frame(input logic [7:0] sd, input logic [31:0] din,
                           input logic [31:0] dexp, input string tag);
    seed_load = 1'b1;
    seed      = sd;
    m4.ready  = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s4.valid = 1'b1;
      s4.data  = din[8*i +: 8];
      tick();
      check({tag, "_data"}, m4.data, dexp[8*i +: 8]);
      check({tag, "_valid"}, m4.valid, 1'b1);
    end
    s4.valid = 1'b0;
    check({tag, "_sready_flush"}, s4.ready, 1'b0);
    tick();
    check({tag, "_frame_done"}, fd4, 1'b1);
    check({tag, "_busy_idle"}, busy4, 1'b0);
    tick();
    check({tag, "_frame_done_pulse"}, fd4, 1'b0);
  endtask

  logic [7:0]  k, sd, p;
  logic [31:0] pt, ct, ex;
  logic [7:0]  q[$];
  int          acc, got, n;

  initial begin
    reset = 1'b1; seed_load = 1'b0; seed = '0;
    s4.valid = 1'b0; s4.data = '0; m4.ready = 1'b0;
    seed_load16 = 1'b0; seed16 = '0;
    s16.valid = 1'b0; s16.data = '0; m16.ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_m_valid", m4.valid, 1'b0);
    check("rst_m_data", m4.data, 8'h00);
    check("rst_busy", busy4, 1'b0);
    check("rst_frame_done", fd4, 1'b0);
    check("rst_s_ready", s4.ready, 1'b0);

    // Keystream from seed 1, zero plaintext.
    run_frame(8'h01, 32'h0000_0000, 32'h2E5C_B801, "t1_keystream");
    // FF,FF -> FE,47 then zeros.
    run_frame(8'h01, 32'h0000_FFFF, 32'h2E5C_47FE, "t2_ff");
    // Zero seed behaves as seed 1.
    run_frame(8'h00, 32'h0000_0000, 32'h2E5C_B801, "t3_zero_seed");

    // Output stall after word 0: data held, no accept, key frozen.
    seed_load = 1'b1; seed = 8'h01; tick(); seed_load = 1'b0;
    m4.ready = 1'b1; s4.valid = 1'b1; s4.data = 8'h00;
    check("t4_sready_run", s4.ready, 1'b1);
    tick();
    check("t4_w0", m4.data, 8'h01);
    m4.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_stall_sready", s4.ready, 1'b0);
      tick();
      check("t4_stall_data", m4.data, 8'h01);
      check("t4_stall_valid", m4.valid, 1'b1);
    end
    m4.ready = 1'b1;
    #1;
    check("t4_release_sready", s4.ready, 1'b1);
    tick(); check("t4_w1", m4.data, 8'hB8);
    tick(); check("t4_w2", m4.data, 8'h5C);
    tick(); check("t4_w3", m4.data, 8'h2E);
    s4.valid = 1'b0;
    tick(); check("t4_frame_done", fd4, 1'b1);
    tick();

    // Seed load during RUN ignored, then reset mid-frame.
    seed_load = 1'b1; seed = 8'h5A; tick(); seed_load = 1'b0;
    m4.ready = 1'b1; s4.valid = 1'b1; s4.data = 8'h00;
    tick(); check("t5_w0", m4.data, 8'h5A);
    seed_load = 1'b1; seed = 8'h33;
    tick(); check("t5_w1", m4.data, 8'h2D);
    seed_load = 1'b0;
    tick(); check("t5_w2_no_reseed", m4.data, 8'hAE);
    s4.valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_m_valid", m4.valid, 1'b0);
    check("t5_rst_busy", busy4, 1'b0);
    check("t5_rst_m_data", m4.data, 8'h00);
    check("t5_rst_s_ready", s4.ready, 1'b0);
    k = 8'h33;
    for (int i = 0; i < 4; i++) begin
      ex[8*i +: 8] = k;
      k = lstep(k);
    end
    check("t5_first_key_hand", ex[7:0], 8'h33);
    run_frame(8'h33, 32'h0000_0000, ex, "t5_rearm");

    // Round trip over random frames.
    for (int f = 0; f < 1000; f++) begin
      sd = 8'($urandom);
      pt = $urandom;
      k  = (sd == 8'h00) ? 8'h01 : sd;
      for (int i = 0; i < 4; i++) begin
        ct[8*i +: 8] = pt[8*i +: 8] ^ k;
        k = lstep(k);
      end
      run_frame(sd, ct, pt, "t2_roundtrip");
    end

    // Random gaps on 16-word frames; queue holds expected plaintext in order.
    for (int f = 0; f < 4; f++) begin
      sd = 8'($urandom);
      seed_load16 = 1'b1; seed16 = sd;
      tick();
      seed_load16 = 1'b0;
      k = (sd == 8'h00) ? 8'h01 : sd;
      acc = 0; got = 0; n = 0;
      q.delete();
      while (got < 16 && n < 600) begin
        p = 8'($urandom);
        s16.valid = (acc < 16) && ($urandom_range(0, 2) != 0);
        s16.data  = p ^ k;
        m16.ready = ($urandom_range(0, 2) != 0);
        #1;
        if (m16.valid && m16.ready) begin
          if (q.size() == 0) begin
            check("t6_unexpected_word", 1'b1, 1'b0);
          end else begin
            check("t6_data", m16.data, q.pop_front());
          end
          got++;
        end
        if (s16.valid && s16.ready) begin
          q.push_back(p);
          k = lstep(k);
          acc++;
        end
        tick();
        n++;
      end
      s16.valid = 1'b0;
      m16.ready = 1'b0;
      check("t6_words_out", got, 16);
      check("t6_words_in", acc, 16);
      check("t6_queue_empty", q.size(), 0);
      check("t6_frame_done", fd16, 1'b1);
      tick();
      check("t6_idle", busy16, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
